// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the 4-bit Gray code path.
//   GRAY_WIDTH  - default Gray/binary word width
//   GRAY_ERR_W  - default width of the step-violation counter
//   GRAY_MAX_W  - widest word the helper functions handle (legal widths 2..16)
//   track_state_t - step tracker states (ST_FIRST, ST_TRACK)
//   gray2bin()  - pure Gray-to-binary decode, shared with encoder-side code
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_WIDTH = 4;
    localparam int GRAY_ERR_W = 8;
    localparam int GRAY_MAX_W = 16;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_TRACK = 1'b1
    } track_state_t;

    // Decodes a zero-extended Gray word. Leading zero Gray bits decode to
    // leading zero binary bits, so callers of any width up to GRAY_MAX_W can
    // zero-extend, decode, and truncate back to their own width.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        // NOTE: blocking assignments inside a function build a combinational
        // ripple; each bit depends on the bit just computed above it.
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_step_checker.sv
// -----------------------------------------------------------------------------
// gray_step_checker
// Combinational comparison of two successive Gray samples.
//   prev_gray, new_gray : previous / current Gray samples
//   prev_bin,  new_bin  : their decoded binary values
//   multi_bit           : more than one Gray bit changed (step violation)
//   is_inc              : new_bin == prev_bin + 1 modulo 2^WIDTH
// -----------------------------------------------------------------------------
module gray_step_checker #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_gray,
    input  logic [WIDTH-1:0] new_gray,
    input  logic [WIDTH-1:0] prev_bin,
    input  logic [WIDTH-1:0] new_bin,
    output logic             multi_bit,
    output logic             is_inc
);

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] prev_plus1;

    assign diff       = prev_gray ^ new_gray;
    // A word with more than one bit set has a non-zero value after clearing
    // its lowest set bit; cheaper than a full population count.
    assign multi_bit  = |(diff & (diff - WIDTH'(1)));
    // Natural WIDTH-bit wrap makes 2^WIDTH-1 -> 0 a legal increment.
    assign prev_plus1 = prev_bin + WIDTH'(1);
    assign is_inc     = (new_bin == prev_plus1);

endmodule

// File: rtl/gray_decoder_tracker.sv
// -----------------------------------------------------------------------------
// gray_decoder_tracker
// Streaming Gray-to-binary decoder with a single-entry registered output and
// an optional step tracker that checks the single-bit-change rule.
//
// Build option: define GRAY_STEP_CHECK_EN to include the step tracker; when
// undefined, dir, step_err and err_count are tied to 0.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   Gray sample present on gray_in
//   in_ready   block can accept a sample this cycle
//   gray_in    Gray-coded sample, MSB is bit WIDTH-1
//   out_valid  bin_out and status outputs hold a decoded result
//   out_ready  consumer accepts the result this cycle
//   bin_out    decoded binary value
//   dir        1 = last step was +1 mod 2^WIDTH, 0 = -1 or hold
//   step_err   current result violated the single-bit-change rule
//   err_count  saturating count of step violations since reset
// -----------------------------------------------------------------------------
module gray_decoder_tracker
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH,
    parameter int ERR_W = GRAY_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             dir,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    logic             accept;
    logic [WIDTH-1:0] new_bin;

    // The output register drains and reloads on the same edge, so a full
    // buffer still accepts whenever the consumer is taking the current result.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign new_bin  = WIDTH'(gray2bin(GRAY_MAX_W'(gray_in)));

    // -------------------------------------------------------------------------
    // Output stage
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bin_out   <= new_bin;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    // -------------------------------------------------------------------------
    // Step tracker
    // -------------------------------------------------------------------------
    track_state_t     state_q;
    track_state_t     state_d;
    logic [WIDTH-1:0] prev_gray_q;
    logic [WIDTH-1:0] prev_bin;
    logic             multi_bit;
    logic             is_inc;
    logic             step_err_d;
    logic             dir_d;
    logic             step_err_q;
    logic             dir_q;
    logic [ERR_W-1:0] err_count_q;

    assign prev_bin = WIDTH'(gray2bin(GRAY_MAX_W'(prev_gray_q)));

    gray_step_checker #(
        .WIDTH (WIDTH)
    ) u_step_checker (
        .prev_gray (prev_gray_q),
        .new_gray  (gray_in),
        .prev_bin  (prev_bin),
        .new_bin   (new_bin),
        .multi_bit (multi_bit),
        .is_inc    (is_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        step_err_d = 1'b0;
        dir_d      = 1'b0;
        case (state_q)
            ST_FIRST: begin
                // No history yet: the first sample can't be judged.
                if (accept) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                step_err_d = multi_bit;
                // A +1 binary step is always a single Gray bit change, so
                // is_inc alone already excludes hold and -1.
                dir_d      = !multi_bit && is_inc;
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray_q <= '0;
            step_err_q  <= 1'b0;
            dir_q       <= 1'b0;
            err_count_q <= '0;
        end else if (accept) begin
            // History advances on every accept, including violating samples,
            // so one bad sample is counted once rather than re-flagged.
            prev_gray_q <= gray_in;
            step_err_q  <= step_err_d;
            dir_q       <= dir_d;
            if (step_err_d && (err_count_q != {ERR_W{1'b1}})) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign step_err  = step_err_q;
    assign dir       = dir_q;
    assign err_count = err_count_q;
`else
    assign step_err  = 1'b0;
    assign dir       = 1'b0;
    assign err_count = '0;
`endif

endmodule
